// File: rtl/imager_capture_scheduler.sv
// -----------------------------------------------------------------------------
// imager_capture_scheduler
//
// Frame-capture sequencer for NUM_CAMS Stonyman channels. It issues
// frame_capture_start pulses from a programmable frame period, either to one
// camera per slot (round-robin) or to all enabled cameras together
// (simultaneous). It then collects the per-channel done pulses and counts the
// frame slots that complete.
//
// Optional watchdog: define IMAGER_SCHED_TIMEOUT_EN to enable it. When the
// macro is undefined, the timeout input is ignored and cam_reset/timeout_err
// are tied to zero.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   enable       run the scheduler
//   mode         0 = round-robin, 1 = simultaneous
//   cam_enable   channel mask (sampled only while issuing)
//   period       start-to-start slot spacing in cycles (0 = back-to-back)
//   timeout      watchdog limit in cycles (0 = disabled)
//   err_clear    clears the sticky timeout_err flags
//   cam_busy     per-channel controller busy
//   cam_done     per-channel capture-done pulse
//   cam_start    one-cycle capture-start pulses
//   cam_reset    one-cycle per-channel reset pulse on watchdog expiry
//   active_cam   last camera started in round-robin mode
//   frame_count  completed slots (wraps)
//   sched_busy   high whenever the FSM is not idle
//   timeout_err  sticky per-channel timeout flags
// -----------------------------------------------------------------------------
module imager_capture_scheduler #(
  parameter int NUM_CAMS    = 2,
  parameter int PERIOD_W    = 24,
  parameter int FRAME_CNT_W = 16,
  parameter int TIMEOUT_W   = 20,
  localparam int AW = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [NUM_CAMS-1:0]    cam_enable,
  input  logic [PERIOD_W-1:0]    period,
  input  logic [TIMEOUT_W-1:0]   timeout,
  input  logic                   err_clear,
  input  logic [NUM_CAMS-1:0]    cam_busy,
  input  logic [NUM_CAMS-1:0]    cam_done,
  output logic [NUM_CAMS-1:0]    cam_start,
  output logic [NUM_CAMS-1:0]    cam_reset,
  output logic [AW-1:0]          active_cam,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   sched_busy,
  output logic [NUM_CAMS-1:0]    timeout_err
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_PERIOD = 2'd1,
    ISSUE       = 2'd2,
    WAIT_DONE   = 2'd3
  } state_t;

  state_t                state_r;
  logic [NUM_CAMS-1:0]   pending_r;
  logic [PERIOD_W-1:0]   period_cnt_r;
  logic                  first_r;      // no round-robin start since reset

  logic [NUM_CAMS-1:0]   target_s;
  logic [NUM_CAMS-1:0]   done_eff_s;
  logic [NUM_CAMS-1:0]   pending_next_s;
  logic [AW-1:0]         rr_idx_s;
  logic [AW-1:0]         hi_idx_s;
  logic [AW-1:0]         lo_idx_s;
  logic                  hi_found_s;
  logic                  lo_found_s;
  logic                  busy_block_s;
  logic                  period_hit_s;
  logic [PERIOD_W-1:0]   cnt_inc_s;

  // Round-robin pick: the lowest enabled camera above active_cam, else wrap to the lowest enabled one.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    // Descending scan so the last hit is the lowest index.
    for (int i = NUM_CAMS - 1; i >= 0; i--) begin
      if (cam_enable[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = AW'(i);
        if (!first_r && (i > int'(active_cam))) begin
          hi_found_s = 1'b1;
          hi_idx_s   = AW'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    rr_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
    if (mode) begin
      target_s = cam_enable;
    end else if (lo_found_s) begin
      target_s = NUM_CAMS'(1) << rr_idx_s;
    end else begin
      target_s = '0;
    end
  end

  // Slot bookkeeping: busy gating, done filtering and the saturating period compare.
  always_comb begin
    busy_block_s   = |(target_s & cam_busy);
    // A done arriving while the start pulse is still on the wire belongs to an earlier capture.
    done_eff_s     = (|cam_start) ? '0 : (cam_done & pending_r);
    pending_next_s = pending_r & ~done_eff_s;
    cnt_inc_s      = (&period_cnt_r) ? period_cnt_r : (period_cnt_r + PERIOD_W'(1));
    // Leave WAIT_PERIOD when the incremented count reaches period-1. ISSUE adds one more
    // cycle, so starts land exactly period cycles apart. The form below is safe for period=0.
    period_hit_s   = (({1'b0, cnt_inc_s} + {{PERIOD_W{1'b0}}, 1'b1}) >= {1'b0, period});
  end

`ifdef IMAGER_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]  wd_r;
  logic [TIMEOUT_W-1:0]  wd_inc_s;
  logic                  wd_hit_s;

  // Watchdog compare: expire when the count reaches a nonzero timeout.
  always_comb begin
    wd_inc_s = (&wd_r) ? wd_r : (wd_r + TIMEOUT_W'(1));
    wd_hit_s = (timeout != '0) && (wd_inc_s >= timeout);
  end
`else
  logic unused_s;
  assign unused_s    = ^{timeout, err_clear};
  assign cam_reset   = '0;
  assign timeout_err = '0;
`endif

  // Scheduler FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pending_r    <= '0;
      period_cnt_r <= '0;
      first_r      <= 1'b1;
      cam_start    <= '0;
      active_cam   <= '0;
      frame_count  <= '0;
      sched_busy   <= 1'b0;
`ifdef IMAGER_SCHED_TIMEOUT_EN
      wd_r         <= '0;
      cam_reset    <= '0;
      timeout_err  <= '0;
`endif
    end else begin
      cam_start    <= '0;
      period_cnt_r <= cnt_inc_s;
`ifdef IMAGER_SCHED_TIMEOUT_EN
      cam_reset    <= '0;
      timeout_err  <= err_clear ? '0 : timeout_err;
`endif
      case (state_r)
        IDLE: begin
          if (enable && (cam_enable != '0)) begin
            state_r    <= ISSUE;
            sched_busy <= 1'b1;
`ifdef IMAGER_SCHED_TIMEOUT_EN
            wd_r       <= '0;
`endif
          end else begin
            state_r    <= IDLE;
            sched_busy <= 1'b0;
          end
        end
        WAIT_PERIOD: begin
          if (!enable) begin
            state_r    <= IDLE;
            sched_busy <= 1'b0;
          end else if (period_hit_s) begin
            state_r    <= ISSUE;
            sched_busy <= 1'b1;
`ifdef IMAGER_SCHED_TIMEOUT_EN
            wd_r       <= '0;
`endif
          end else begin
            state_r    <= WAIT_PERIOD;
            sched_busy <= 1'b1;
          end
        end
        ISSUE: begin
          if (target_s == '0) begin
            state_r      <= WAIT_PERIOD;
            sched_busy   <= 1'b1;
          end else if (!busy_block_s) begin
            cam_start    <= target_s;
            pending_r    <= target_s;
            period_cnt_r <= '0;
            state_r      <= WAIT_DONE;
            sched_busy   <= 1'b1;
`ifdef IMAGER_SCHED_TIMEOUT_EN
            wd_r         <= '0;
`endif
            if (!mode) begin
              active_cam <= rr_idx_s;
              first_r    <= 1'b0;
            end else begin
              active_cam <= active_cam;
            end
          end
`ifdef IMAGER_SCHED_TIMEOUT_EN
          else if (wd_hit_s) begin
            // Selected channels stayed busy too long. Reset them and skip this slot,
            // but still advance the round-robin pointer.
            timeout_err  <= (err_clear ? '0 : timeout_err) | target_s;
            cam_reset    <= target_s;
            state_r      <= enable ? WAIT_PERIOD : IDLE;
            sched_busy   <= enable;
            if (!mode) begin
              active_cam <= rr_idx_s;
              first_r    <= 1'b0;
            end else begin
              active_cam <= active_cam;
            end
          end else begin
            wd_r         <= wd_inc_s;
          end
`else
          else begin
            state_r      <= ISSUE;
          end
`endif
        end
        WAIT_DONE: begin
          if (pending_next_s == '0) begin
            pending_r   <= '0;
            frame_count <= frame_count + FRAME_CNT_W'(1);
            state_r     <= enable ? WAIT_PERIOD : IDLE;
            sched_busy  <= enable;
          end
`ifdef IMAGER_SCHED_TIMEOUT_EN
          else if (wd_hit_s) begin
            timeout_err <= (err_clear ? '0 : timeout_err) | pending_next_s;
            cam_reset   <= pending_next_s;
            pending_r   <= '0;
            state_r     <= enable ? WAIT_PERIOD : IDLE;
            sched_busy  <= enable;
          end else begin
            pending_r   <= pending_next_s;
            wd_r        <= wd_inc_s;
          end
`else
          else begin
            pending_r   <= pending_next_s;
          end
`endif
        end
        default: begin
          state_r    <= IDLE;
          pending_r  <= '0;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imager_capture_scheduler.sv
// -----------------------------------------------------------------------------
// tb_imager_capture_scheduler
//
// Testbench for imager_capture_scheduler with NUM_CAMS=2. The stimulus process
// queues the expected start pulses. A monitor pops one entry for each start
// the DUT emits and checks the mask, the pointer, the count and the timing.
// A small camera model answers each start with a done pulse after a
// programmable delay.
// -----------------------------------------------------------------------------
module tb_imager_capture_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [1:0]  cam_enable;
  logic [23:0] period;
  logic [19:0] timeout;
  logic        err_clear;
  logic [1:0]  cam_busy;
  logic [1:0]  cam_done;
  logic [1:0]  cam_start;
  logic [1:0]  cam_reset;
  logic        active_cam;
  logic [15:0] frame_count;
  logic        sched_busy;
  logic [1:0]  timeout_err;

  logic [1:0]  model_done = 2'b00;
  logic [1:0]  stray_done;
  assign cam_done = model_done | stray_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int starts_seen = 0;
  int last_start_cyc = 0;
  int start_base = 0;
  int dly [2];
  bit never [2];
  int cnt [2];

  typedef struct {
    logic [1:0]  st;
    logic        ac;
    logic [15:0] fc;
    int          gap;
    int          abs_cyc;
  } exp_t;
  exp_t q [$];

  imager_capture_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .cam_enable(cam_enable), .period(period), .timeout(timeout),
    .err_clear(err_clear), .cam_busy(cam_busy), .cam_done(cam_done),
    .cam_start(cam_start), .cam_reset(cam_reset), .active_cam(active_cam),
    .frame_count(frame_count), .sched_busy(sched_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic ac, input logic [15:0] fc,
                      input int gap, input int abs_c);
    exp_t e;
    e.st = st; e.ac = ac; e.fc = fc; e.gap = gap; e.abs_cyc = abs_c;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k = 0;
    while ((starts_seen < start_base + n) && (k < budget)) begin
      step(1);
      k++;
    end
    chk(name, 32'(starts_seen >= start_base + n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (sched_busy && (k < budget)) begin
      step(1);
      k++;
    end
    chk(name, 32'(sched_busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; mode = 1'b0; cam_enable = 2'b00;
    period = 24'd0; timeout = 20'd0; err_clear = 1'b0; cam_busy = 2'b00;
    stray_done = 2'b00;
    dly[0] = 1; dly[1] = 1; never[0] = 1'b0; never[1] = 1'b0;
    step(3);
    reset = 1'b0;
    start_base = starts_seen;
  endtask

  // cycle counter: number of rising edges so far
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // camera model: done pulse dly cycles after the start pulse is seen
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_done[i] = 1'b0;
      if (reset) begin
        cnt[i] = 0;
      end else if (cam_start[i]) begin
        cnt[i] = never[i] ? 0 : dly[i];
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) model_done[i] = 1'b1;
      end
    end
  end

  // monitor: every start pulse consumes one expected entry
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset && (cam_start != 2'b00)) begin
      if (q.size() == 0) begin
        chk("unexpected_start", 32'(cam_start), 32'd0);
      end else begin
        e = q.pop_front();
        chk("start_mask", 32'(cam_start), 32'(e.st));
        chk("start_active_cam", 32'(active_cam), 32'(e.ac));
        chk("start_frame_count", 32'(frame_count), 32'(e.fc));
        if (e.gap >= 0) chk("start_gap", 32'(cyc - last_start_cyc), 32'(e.gap));
        if (e.abs_cyc >= 0) chk("start_cycle", 32'(cyc), 32'(e.abs_cyc));
      end
      last_start_cyc = cyc;
      starts_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time bound expired");
  end

  initial begin
    // reset state
    do_reset();
    step(1);
    chk("rst_cam_start", 32'(cam_start), 32'd0);
    chk("rst_cam_reset", 32'(cam_reset), 32'd0);
    chk("rst_active_cam", 32'(active_cam), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    enable = 1'b1;
    step(3);
    chk("idle_no_cams", 32'(sched_busy), 32'd0);
    enable = 1'b0;

    // 1: round-robin, back-to-back, done 10 cycles after start
    do_reset();
    cam_enable = 2'b11; dly[0] = 10; dly[1] = 10;
    push(2'b01, 1'b0, 16'd0, -1, cyc + 2);
    push(2'b10, 1'b1, 16'd1, 13, -1);
    push(2'b01, 1'b0, 16'd2, 13, -1);
    enable = 1'b1;
    wait_starts(3, 200, "t1_wait_starts");
    enable = 1'b0;
    wait_idle(100, "t1_idle");
    chk("t1_frame_count", 32'(frame_count), 32'd3);
    chk("t1_active_cam", 32'(active_cam), 32'd0);

    // 2: simultaneous, period 100, dones at +8 and +13
    do_reset();
    mode = 1'b1; cam_enable = 2'b11; period = 24'd100; dly[0] = 8; dly[1] = 13;
    push(2'b11, 1'b0, 16'd0, -1, -1);
    push(2'b11, 1'b0, 16'd1, 100, -1);
    enable = 1'b1;
    wait_starts(1, 20, "t2_wait_first");
    step(11);
    chk("t2_count_before_cam1", 32'(frame_count), 32'd0);
    step(4);
    chk("t2_count_after_cam1", 32'(frame_count), 32'd1);
    wait_starts(2, 150, "t2_wait_second");
    enable = 1'b0;
    wait_idle(100, "t2_idle");
    chk("t2_frame_count", 32'(frame_count), 32'd2);

    // 3: round-robin with only cam1 enabled
    do_reset();
    cam_enable = 2'b10; dly[1] = 4;
    push(2'b10, 1'b1, 16'd0, -1, -1);
    push(2'b10, 1'b1, 16'd1, 7, -1);
    push(2'b10, 1'b1, 16'd2, 7, -1);
    enable = 1'b1;
    wait_starts(3, 100, "t3_wait_starts");
    enable = 1'b0;
    wait_idle(50, "t3_idle");
    chk("t3_active_cam", 32'(active_cam), 32'd1);
    chk("t3_frame_count", 32'(frame_count), 32'd3);

    // 4: cam0 busy for 20 cycles holds the first start
    do_reset();
    cam_enable = 2'b11; dly[0] = 3; dly[1] = 3; cam_busy = 2'b01;
    enable = 1'b1;
    step(20);
    push(2'b01, 1'b0, 16'd0, -1, cyc + 1);
    cam_busy = 2'b00;
    wait_starts(1, 10, "t4_wait_start");
    enable = 1'b0;
    wait_idle(50, "t4_idle");

    // 5: cam0 never answers
    do_reset();
    cam_enable = 2'b11; timeout = 20'd50; never[0] = 1'b1; dly[1] = 5;
`ifdef IMAGER_SCHED_TIMEOUT_EN
    push(2'b01, 1'b0, 16'd0, -1, -1);
    push(2'b10, 1'b1, 16'd0, 52, -1);
    enable = 1'b1;
    wait_starts(1, 20, "t5_wait_first");
    step(49);
    chk("t5_err_before", 32'(timeout_err), 32'd0);
    chk("t5_rst_before", 32'(cam_reset), 32'd0);
    step(1);
    chk("t5_err_at_timeout", 32'(timeout_err), 32'd1);
    chk("t5_rst_at_timeout", 32'(cam_reset), 32'd1);
    chk("t5_count_at_timeout", 32'(frame_count), 32'd0);
    step(1);
    chk("t5_rst_one_cycle", 32'(cam_reset), 32'd0);
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);
    wait_starts(2, 20, "t5_wait_second");
    enable = 1'b0;
    wait_idle(50, "t5_idle");
    chk("t5_frame_count", 32'(frame_count), 32'd1);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    chk("t5_err_cleared", 32'(timeout_err), 32'd0);
`else
    push(2'b01, 1'b0, 16'd0, -1, -1);
    enable = 1'b1;
    wait_starts(1, 20, "t5_wait_first");
    step(60);
    chk("t5_hold_busy", 32'(sched_busy), 32'd1);
    chk("t5_hold_count", 32'(frame_count), 32'd0);
    chk("t5_no_reset", 32'(cam_reset), 32'd0);
    chk("t5_no_err", 32'(timeout_err), 32'd0);
`endif

    // 6: reset while waiting for a done, with stray dones
    do_reset();
    cam_enable = 2'b11; dly[0] = 3; never[1] = 1'b1;
    push(2'b01, 1'b0, 16'd0, -1, -1);
    push(2'b10, 1'b1, 16'd1, -1, -1);
    enable = 1'b1;
    wait_starts(2, 40, "t6_wait_starts");
    step(5);
    reset = 1'b1; enable = 1'b0; stray_done = 2'b11;
    step(1);
    chk("t6_cam_start", 32'(cam_start), 32'd0);
    chk("t6_active_cam", 32'(active_cam), 32'd0);
    chk("t6_frame_count", 32'(frame_count), 32'd0);
    chk("t6_sched_busy", 32'(sched_busy), 32'd0);
    chk("t6_cam_reset", 32'(cam_reset), 32'd0);
    chk("t6_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0; stray_done = 2'b00;
    step(3);
    chk("t6_stays_idle", 32'(sched_busy), 32'd0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
